// File: rtl/div_sequencer_if.sv
// Handshake and result bundle between the E-stage issue logic and the
// iterative divider.
interface div_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cancel;
  logic             stall_div;
  logic             result_valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;

  modport master (
    output start, signed_div, opa, opb, cancel,
    input  stall_div, result_valid, quotient, remainder, busy
  );

  modport slave (
    input  start, signed_div, opa, opb, cancel,
    output stall_div, result_valid, quotient, remainder, busy
  );
endinterface

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// with a divide-by-zero shortcut and a sign fix-up on the last step.
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           resetn,
  div_sequencer_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ZERO, ON, DONE} stateT;

  stateT            state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] partRem;
  logic [WIDTH-1:0] divisor;
  logic             isSigned;
  logic             signA;
  logic             signB;
  logic             resultValid;
  logic [WIDTH-1:0] quotientR;
  logic [WIDTH-1:0] remainderR;

  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   shifted;
  logic             qBit;
  logic [WIDTH-1:0] nextQuo;
  logic [WIDTH-1:0] nextRem;
  logic             negQ;
  logic             negR;

  always_comb begin
    absA    = (bus.signed_div && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
    absB    = (bus.signed_div && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
    // quo doubles as the dividend shift register: its MSB feeds the partial remainder
    shifted = {partRem, quo[WIDTH-1]};
    qBit    = (shifted >= {1'b0, divisor});
    nextRem = qBit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    nextQuo = {quo[WIDTH-2:0], qBit};
    negQ    = isSigned & (signA ^ signB);
    negR    = isSigned & signA;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      count       <= '0;
      quo         <= '0;
      partRem     <= '0;
      divisor     <= '0;
      isSigned    <= 1'b0;
      signA       <= 1'b0;
      signB       <= 1'b0;
      resultValid <= 1'b0;
      quotientR   <= '0;
      remainderR  <= '0;
    end else begin
      resultValid <= 1'b0;
      if (bus.cancel) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              count   <= '0;
              partRem <= '0;
              if (bus.opb == '0) begin
                // raw dividend parked in quo so ZERO can return it unchanged
                quo   <= bus.opa;
                state <= ZERO;
              end else begin
                quo      <= absA;
                divisor  <= absB;
                isSigned <= bus.signed_div;
                signA    <= bus.signed_div & bus.opa[WIDTH-1];
                signB    <= bus.signed_div & bus.opb[WIDTH-1];
                state    <= ON;
              end
            end
          end
          ZERO: begin
            quotientR   <= '0;
            remainderR  <= quo;
            resultValid <= 1'b1;
            state       <= DONE;
          end
          ON: begin
            quo     <= nextQuo;
            partRem <= nextRem;
            count   <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
              quotientR   <= negQ ? -nextQuo : nextQuo;
              remainderR  <= negR ? -nextRem : nextRem;
              resultValid <= 1'b1;
              state       <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.result_valid = resultValid;
  assign bus.quotient     = quotientR;
  assign bus.remainder    = remainderR;
  assign bus.busy         = (state != IDLE);
  assign bus.stall_div    = bus.start & ~bus.cancel & (state != DONE);
endmodule
